// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/opcode and registered-result bundle for the alu execute stage
//
// Purpose: groups the controller-driven operands/opcode with the alu's
//          registered result and status flags.
// Parameters:
//   BUS_WIDTH  operand/result width in bits (>= 2)
// Signals:
//   a, b        operands                     (controller -> alu)
//   carry_in    carry input for ADD_CARRY    (controller -> alu)
//   opcode      4-bit operation select       (controller -> alu)
//   y           registered result            (alu -> downstream)
//   carry_out   registered carry out of MSB  (alu -> downstream)
//   borrow      registered unsigned borrow   (alu -> downstream)
//   zero        registered y == 0 flag       (alu -> downstream)
//   parity      registered ^y                (alu -> downstream)
//   invalid_op  registered undefined-opcode  (alu -> downstream)
// Modports: master = controller side, slave = alu side.
interface alu_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic                 carry_in;
  logic [3:0]           opcode;
  logic [BUS_WIDTH-1:0] y;
  logic                 carry_out;
  logic                 borrow;
  logic                 zero;
  logic                 parity;
  logic                 invalid_op;

  modport master (
    output a, b, carry_in, opcode,
    input  y, carry_out, borrow, zero, parity, invalid_op
  );

  modport slave (
    input  a, b, carry_in, opcode,
    output y, carry_out, borrow, zero, parity, invalid_op
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - registered nine-operation integer alu with carry/borrow/zero/parity/invalid flags
//
// Purpose: single-cycle execute stage. Inputs sampled on the rising edge,
//          result and flags registered on that same edge (latency 1,
//          throughput 1 per cycle, no handshake).
// Parameters:
//   BUS_WIDTH  operand/result width in bits (>= 2); must match the interface.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset, clears every output register
//   bus    alu_if.slave: a, b, carry_in, opcode in; y and flags out
module alu #(
  parameter int BUS_WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  localparam int W = BUS_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;

  logic [W:0]   w_sum;
  logic [W-1:0] w_y;
  logic         w_carry;
  logic         w_borrow;
  logic         w_invalid;
  logic         w_zero;
  logic         w_parity;

  logic [W-1:0] r_y;
  logic         r_carry;
  logic         r_borrow;
  logic         r_zero;
  logic         r_parity;
  logic         r_invalid;

  always_comb begin
    w_sum     = '0;
    w_y       = '0;
    w_carry   = 1'b0;
    w_borrow  = 1'b0;
    w_invalid = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        // One extra bit so the carry falls out of the adder's MSB.
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_y     = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_ADDC: begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.carry_in};
        w_y     = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_SUB: begin
        w_y      = bus.a - bus.b;
        w_borrow = (bus.a < bus.b);
      end
      OP_INC: begin
        w_sum   = {1'b0, bus.a} + {{W{1'b0}}, 1'b1};
        w_y     = w_sum[W-1:0];
        w_carry = w_sum[W];
      end
      OP_DEC: begin
        w_y      = bus.a - {{(W-1){1'b0}}, 1'b1};
        w_borrow = (bus.a == '0);
      end
      OP_AND: w_y = bus.a & bus.b;
      OP_NOT: w_y = ~bus.a;
      OP_ROL: w_y = {bus.a[W-2:0], bus.a[W-1]};
      OP_ROR: w_y = {bus.a[0], bus.a[W-1:1]};
      default: w_invalid = 1'b1;
    endcase
  end

  // y is forced to 0 on an invalid opcode, so zero must be masked there;
  // parity of an all-zero y is already 0.
  assign w_zero   = ~w_invalid & (w_y == '0);
  assign w_parity = ^w_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_carry   <= 1'b0;
      r_borrow  <= 1'b0;
      r_zero    <= 1'b0;
      r_parity  <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_y       <= w_y;
      r_carry   <= w_carry;
      r_borrow  <= w_borrow;
      r_zero    <= w_zero;
      r_parity  <= w_parity;
      r_invalid <= w_invalid;
    end
  end

  assign bus.y          = r_y;
  assign bus.carry_out  = r_carry;
  assign bus.borrow     = r_borrow;
  assign bus.zero       = r_zero;
  assign bus.parity     = r_parity;
  assign bus.invalid_op = r_invalid;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard-driven self-checking bench for alu (BUS_WIDTH = 8)
module tb_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         bo;
    logic         z;
    logic         p;
    logic         inv;
  } res_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    res_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  alu_if #(.BUS_WIDTH(W)) bus ();

  alu #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic res_t sample();
    return {bus.y, bus.carry_out, bus.borrow, bus.zero, bus.parity, bus.invalid_op};
  endfunction

  // Directed vector: expected y, carry, borrow, invalid given; zero/parity follow y.
  function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic [W-1:0] y, input logic c,
                              input logic bo, input logic inv);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.exp.y = y; v.exp.c = c; v.exp.bo = bo; v.exp.inv = inv;
    v.exp.z = !inv && (y == 0);
    v.exp.p = ^y;
    return v;
  endfunction

  // Independent integer reference used for the randomised back-to-back run.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    res_t r;
    int   s;
    int   ia;
    int   ib;
    r  = '0;
    ia = int'(a);
    ib = int'(b);
    s  = 0;
    case (op)
      4'd1: begin s = ia + ib;            r.c = (s > 255); end
      4'd2: begin s = ia + ib + int'(cin); r.c = (s > 255); end
      4'd3: begin s = ia - ib;            r.bo = (s < 0); end
      4'd4: begin s = ia + 1;             r.c = (s > 255); end
      4'd5: begin s = ia - 1;             r.bo = (s < 0); end
      4'd6: s = int'(a & b);
      4'd7: s = 255 - ia;
      4'd8: s = (ia * 2) % 256 + ia / 128;
      4'd9: s = ia / 2 + (ia % 2) * 128;
      default: r.inv = 1'b1;
    endcase
    r.y = r.inv ? '0 : W'(s & 255);
    r.z = !r.inv && (r.y == 0);
    r.p = ^r.y;
    return r;
  endfunction

  // Drives one operation at the falling edge and records its expected result.
  task automatic drive_vec(input vec_t v);
    @(negedge clk);
    bus.opcode   = v.op;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.carry_in = v.cin;
    sb.push_back(v.exp);
  endtask

  task automatic test_reset();
    res_t act;
    res_t e;
    @(negedge clk);
    rst_n = 1'b0; bus.a = 8'd9; bus.b = 8'd33; bus.opcode = 4'd1; bus.carry_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      act = sample();
      checks++;
      if (act !== res_t'(0)) begin
        errors++;
        $display("FAIL reset[%0d]: got %h, expected all-zero outputs", i, act);
      end
    end
    rst_n = 1'b1;
    drive_vec(mk(4'd1, 8'd9, 8'd33, 1'b0, 8'd42, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    act = sample();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL reset_release: got %h, expected %h", act, e);
    end
  endtask

  task automatic test_add();
    vec_t v[$];
    res_t act;
    res_t e;
    v.push_back(mk(4'd1, 8'd9,   8'd33, 1'b0, 8'd42, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd2, 8'd9,   8'd33, 1'b1, 8'd43, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd1, 8'd9,   8'd33, 1'b1, 8'd42, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd1, 8'd200, 8'd56, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0));
    v.push_back(mk(4'd2, 8'd255, 8'd0,  1'b1, 8'd0,  1'b1, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive_vec(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      act = sample();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL add[%0d] op=%0d a=%0d b=%0d: got %h, expected %h", i, v[i].op, v[i].a, v[i].b, act, e);
      end
    end
  endtask

  task automatic test_sub_inc_dec();
    vec_t v[$];
    res_t act;
    res_t e;
    v.push_back(mk(4'd3, 8'd65,  8'd64,  1'b1, 8'd1,   1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd3, 8'd5,   8'd8,   1'b0, 8'd253, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(4'd3, 8'd7,   8'd7,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd5, 8'd1,   8'hAA,  1'b1, 8'd0,   1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd5, 8'd0,   8'hAA,  1'b1, 8'd255, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(4'd4, 8'd223, 8'hFF,  1'b1, 8'd224, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd4, 8'd255, 8'h55,  1'b0, 8'd0,   1'b1, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive_vec(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      act = sample();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL sub_inc_dec[%0d] op=%0d a=%0d b=%0d: got %h, expected %h", i, v[i].op, v[i].a, v[i].b, act, e);
      end
    end
  endtask

  task automatic test_logic_rotate();
    vec_t v[$];
    res_t act;
    res_t e;
    v.push_back(mk(4'd6, 8'h02, 8'h03, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd7, 8'h02, 8'h00, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd8, 8'h01, 8'hFF, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd8, 8'h80, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd9, 8'h80, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(4'd9, 8'h01, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive_vec(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      act = sample();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL logic_rotate[%0d] op=%0d a=%h: got %h, expected %h", i, v[i].op, v[i].a, act, e);
      end
    end
  endtask

  task automatic test_invalid();
    vec_t v[$];
    res_t act;
    res_t e;
    v.push_back(mk(4'd0,  8'd5, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(4'd12, 8'd5, 8'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(4'd10, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(4'd15, 8'd5, 8'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(4'd1,  8'd5, 8'd3, 1'b0, 8'd8, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive_vec(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      act = sample();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL invalid[%0d] op=%0d: got %h, expected %h", i, v[i].op, act, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    res_t act;
    res_t e;
    for (int n = 0; n < 27; n++) begin
      v.op  = 4'((n % 9) + 1);
      v.a   = W'($urandom_range(0, 255));
      v.b   = W'($urandom_range(0, 255));
      v.cin = 1'($urandom_range(0, 1));
      v.exp = model(v.op, v.a, v.b, v.cin);
      drive_vec(v);
      @(posedge clk); #1;
      if (sb.size() != 1) begin
        errors++;
        checks++;
        $display("FAIL b2b[%0d]: scoreboard depth %0d, expected 1", n, sb.size());
        sb.delete();
      end else begin
        e = sb.pop_front();
        act = sample();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL b2b[%0d] op=%0d a=%0d b=%0d cin=%b: got %h, expected %h", n, v.op, v.a, v.b, v.cin, act, e);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    res_t act;
    res_t e;
    drive_vec(mk(4'd7, 8'h0F, 8'h00, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    act = sample();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL midstream_pre: got %h, expected %h", act, e);
    end
    // The operation sampled under reset is discarded, so nothing is queued for it.
    @(negedge clk);
    rst_n = 1'b0; bus.opcode = 4'd1; bus.a = 8'd100; bus.b = 8'd1;
    @(posedge clk); #1;
    act = sample();
    checks++;
    if (act !== res_t'(0)) begin
      errors++;
      $display("FAIL midstream_reset: got %h, expected all-zero outputs", act);
    end
    rst_n = 1'b1;
    drive_vec(mk(4'd3, 8'd100, 8'd1, 1'b0, 8'd99, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    act = sample();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL midstream_post: got %h, expected %h", act, e);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;
    bus.opcode   = 4'd0;
    test_reset();
    test_add();
    test_sub_inc_dec();
    test_logic_rotate();
    test_invalid();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
